// File: rtl/frame_capture_pkg.sv
// Shared constants and state encoding for the frame-capture sink and the
// median-filter top that feeds it.
package frame_capture_pkg;

   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_IMG_W        = 256;
   localparam int DEF_IMG_H        = 256;
   localparam int DEF_ADDR_W       = 16;
   localparam int DEF_FRAME_PIXELS = DEF_IMG_W * DEF_IMG_H;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_e;

endpackage

// File: rtl/frame_capture_ram.sv
// Single-port synchronous RAM: one write or one read per cycle.
// Read data is registered and only changes on an enabled read.
module capture_ram
   import frame_capture_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_W     = DEF_ADDR_W
) (
   input  logic                  clk,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_W];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_capture.sv
// Captures one raster-order frame of valid-qualified pixels into RAM and
// serves address-based readback once the capture is idle or complete.
module frame_capture
   import frame_capture_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int IMG_W      = DEF_IMG_W,
   parameter int IMG_H      = DEF_IMG_H,
   parameter int ADDR_W     = DEF_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   input  logic                  VALID_IN,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overflow,
   output logic [ADDR_W:0]       pix_count
);

   localparam int FRAME_PIXELS = IMG_W * IMG_H;
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int PW = ADDR_W + 1;

   state_e          state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [PW-1:0]   pix_q, pix_d;
   logic            overflow_q, overflow_d;
   logic            frame_done_q, frame_done_d;
   logic            rd_valid_q, rd_valid_d;
   logic            rd_zero_q, rd_zero_d;

   logic            ram_en, ram_we;
   logic [ADDR_W-1:0]     ram_addr, wr_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic            rd_oor;

   assign wr_addr = ADDR_W'(32'(row_q) * 32'(IMG_W) + 32'(col_q));
   assign rd_oor  = ({1'b0, rd_addr} >= PW'(FRAME_PIXELS));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         pix_q        <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_zero_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         pix_q        <= pix_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
         rd_valid_q   <= rd_valid_d;
         rd_zero_q    <= rd_zero_d;
      end
   end

   // The single RAM port belongs to the writer in CAPTURE and to readback otherwise.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      pix_d        = pix_q;
      overflow_d   = overflow_q;
      frame_done_d = 1'b0;
      rd_valid_d   = 1'b0;
      rd_zero_d    = rd_zero_q;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = rd_addr;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = CAPTURE;
               col_d      = '0;
               row_d      = '0;
               pix_d      = '0;
               overflow_d = 1'b0;
            end else if (state_q == DONE && VALID_IN) begin
               overflow_d = 1'b1;
            end
            if (rd_en) begin
               ram_en     = 1'b1;
               rd_valid_d = 1'b1;
               rd_zero_d  = rd_oor;
            end
         end
         CAPTURE: begin
            ram_addr = wr_addr;
            if (VALID_IN) begin
               ram_en = 1'b1;
               ram_we = 1'b1;
               pix_d  = pix_q + PW'(1);
               if (col_q == CW'(IMG_W - 1)) begin
                  col_d = '0;
                  if (row_q == RW'(IMG_H - 1)) begin
                     row_d        = '0;
                     state_d      = DONE;
                     frame_done_d = 1'b1;
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   capture_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (DATA_IN),
      .rdata_o (ram_rdata)
   );

   // Out-of-range reads (and the post-reset state) present zero without touching RAM data.
   assign rd_data    = rd_zero_q ? '0 : ram_rdata;
   assign rd_valid   = rd_valid_q;
   assign busy       = (state_q == CAPTURE);
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign pix_count  = pix_q;

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture on a small 4x3 frame.
module tb_frame_capture;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [DW-1:0] DATA_IN;
   logic          VALID_IN;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          busy;
   logic          frame_done;
   logic          overflow;
   logic [AW:0]   pix_count;

   int errors = 0;
   int checks = 0;
   int fd_cnt = 0;
   int fd_base;

   frame_capture #(
      .DATA_WIDTH (DW),
      .IMG_W      (W),
      .IMG_H      (H),
      .ADDR_W     (AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .DATA_IN    (DATA_IN),
      .VALID_IN   (VALID_IN),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .frame_done (frame_done),
      .overflow   (overflow),
      .pix_count  (pix_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      DATA_IN  = d;
      VALID_IN = 1'b1;
      tick();
      VALID_IN = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en   = 1'b0;
      chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
      chk({tag, "_data"}, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; DATA_IN = '0; VALID_IN = 1'b0;
      rd_en = 1'b0; rd_addr = '0;

      // Reset held with random activity on the inputs
      for (int i = 0; i < 4; i++) begin
         start    = 1'($urandom);
         VALID_IN = 1'($urandom);
         DATA_IN  = 8'($urandom);
         rd_en    = 1'($urandom);
         rd_addr  = 4'($urandom);
         tick();
      end
      chk("rst_busy", 32'(busy), 0);
      chk("rst_fdone", 32'(frame_done), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_rvalid", 32'(rd_valid), 0);
      chk("rst_rdata", 32'(rd_data), 0);
      chk("rst_pix", 32'(pix_count), 0);
      start = 1'b0; VALID_IN = 1'b0; rd_en = 1'b0;
      reset = 1'b1;
      tick();

      // Pixels in IDLE and alongside start are dropped
      DATA_IN = 8'hAA; VALID_IN = 1'b1;
      tick();
      chk("idle_pix", 32'(pix_count), 0);
      chk("idle_ovf", 32'(overflow), 0);
      chk("idle_busy", 32'(busy), 0);
      DATA_IN = 8'hBB; VALID_IN = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; VALID_IN = 1'b0;
      chk("start_busy", 32'(busy), 1);
      chk("start_pix", 32'(pix_count), 0);
      push(8'h01);
      chk("first_pix", 32'(pix_count), 1);
      chk("first_ovf", 32'(overflow), 0);
      for (int i = 1; i < W * H; i++) push(8'(i + 1));
      chk("f1_fdone", 32'(frame_done), 1);
      tick();
      rd(4'd0, 8'h01, "f1_a0");
      rd(4'd11, 8'h0C, "f1_a11");

      // Full frame with gaps between pixels
      fd_base = fd_cnt;
      pulse_start();
      for (int i = 0; i < W * H; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         if (i == W * H - 1) chk("f2_no_early_fd", 32'(fd_cnt - fd_base), 0);
         push(8'(i));
      end
      chk("f2_fdone", 32'(frame_done), 1);
      chk("f2_pix", 32'(pix_count), 12);
      chk("f2_busy", 32'(busy), 0);
      tick();
      chk("f2_fdone_drop", 32'(frame_done), 0);
      chk("f2_fd_once", 32'(fd_cnt - fd_base), 1);
      chk("f2_pix_hold", 32'(pix_count), 12);
      rd(4'd5, 8'h05, "f2_a5");
      rd(4'd12, 8'h00, "f2_a12");
      rd(4'd7, 8'h07, "f2_a7");
      tick();
      chk("rvalid_idle", 32'(rd_valid), 0);

      // Overflow after frame complete
      push(8'hFF);
      chk("ovf_set", 32'(overflow), 1);
      repeat (3) tick();
      chk("ovf_hold", 32'(overflow), 1);
      chk("ovf_pix", 32'(pix_count), 12);
      rd(4'd0, 8'h00, "ovf_a0");
      rd(4'd5, 8'h05, "pre_a5");
      pulse_start();
      chk("ovf_clr", 32'(overflow), 0);
      chk("ovf_busy", 32'(busy), 1);

      // Reads ignored during capture, then async reset mid-frame
      rd_en = 1'b1; rd_addr = 4'd1;
      tick();
      rd_en = 1'b0;
      chk("cap_rvalid", 32'(rd_valid), 0);
      chk("cap_rdata_hold", 32'(rd_data), 8'h05);
      for (int i = 0; i < 7; i++) push(8'(8'hE0 + i));
      chk("part_pix", 32'(pix_count), 7);
      fd_base = fd_cnt;
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("async_busy", 32'(busy), 0);
      chk("async_pix", 32'(pix_count), 0);
      chk("async_rdata", 32'(rd_data), 0);
      #2 reset = 1'b1;
      repeat (2) tick();
      chk("async_no_fd", 32'(fd_cnt - fd_base), 0);
      chk("async_idle", 32'(busy), 0);

      pulse_start();
      for (int i = 0; i < W * H; i++) begin
         if (i % 3 == 1) tick();
         push(8'(8'h30 + i));
      end
      chk("f3_fd_once", 32'(fd_cnt - fd_base), 0);
      tick();
      chk("f3_fd_count", 32'(fd_cnt - fd_base), 1);
      for (int a = 0; a < W * H; a++) rd(4'(a), 8'(8'h30 + a), $sformatf("f3_a%0d", a));
      rd(4'd15, 8'h00, "f3_a15");
      tick();
      chk("f3_rvalid_end", 32'(rd_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
